// File: rtl/bcd_subtractor_serial_pkg.sv
// Shared constants for the digit-serial BCD subtractor.
package bcd_subtractor_serial_pkg;

    localparam int unsigned DIGIT_W  = 4;
    localparam logic [3:0]  BCD_NINE = 4'd9;

    // FSM state encodings
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Digit counter width, never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bcd_subtractor_serial_bcd_adder.sv
// Single BCD digit adder: sum = (a + b + cin) with decimal correction.
module bcd_adder (
    output logic [3:0] sum,
    output logic       cout,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin
);

    logic [4:0] raw;

    // Binary add, then +6 correction when the digit exceeds nine.
    always_comb begin
        raw  = 5'({1'b0, a}) + 5'({1'b0, b}) + 5'({4'b0, cin});
        sum  = raw[3:0];
        cout = 1'b0;
        if (raw > 5'd9) begin
            sum  = 4'(raw[3:0] + 4'd6);
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial packed-BCD subtractor: diff = (x - y - bin) mod 10^M, LSD first,
// using nine's-complement addition through one BCD digit adder.
module bcd_subtractor_serial
    import bcd_subtractor_serial_pkg::*;
#(
    parameter int unsigned N = 12,
    parameter int unsigned M = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         err
);

    localparam int unsigned CNT_W = cnt_w(M);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [N-1:0]     x_sh_q,  x_sh_d;
    logic [N-1:0]     y_sh_q,  y_sh_d;
    logic [N-1:0]     res_q,   res_d;
    logic [N-1:0]     diff_q,  diff_d;
    logic             carry_q, carry_d;
    logic             bout_q,  bout_d;
    logic             err_q,   err_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [3:0]         dig_a;
    logic [3:0]         dig_b;
    logic [3:0]         dig_sum;
    logic               dig_cout;
    logic [N+3:0]       acc;
    logic [N-1:0]       res_next;
    logic               bad_digit;

    // Current digit: minuend digit plus nine's complement of subtrahend digit.
    assign dig_a = x_sh_q[DIGIT_W-1:0];
    assign dig_b = BCD_NINE - y_sh_q[DIGIT_W-1:0];

    bcd_adder u_digit (
        .sum  (dig_sum),
        .cout (dig_cout),
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry_q)
    );

    // New sum digit enters the result register from the MSD end.
    assign acc      = {dig_sum, res_q};
    assign res_next = acc[N+DIGIT_W-1:DIGIT_W];

    // Flag any non-decimal digit on the incoming operands.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < int'(M); i++) begin
            if ((x[i*DIGIT_W +: DIGIT_W] > BCD_NINE) ||
                (y[i*DIGIT_W +: DIGIT_W] > BCD_NINE)) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_sh_d  = x_sh_q;
        y_sh_d  = y_sh_q;
        res_d   = res_q;
        diff_d  = diff_q;
        carry_d = carry_q;
        bout_d  = bout_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    x_sh_d  = x;
                    y_sh_d  = y;
                    carry_d = ~bin;
                    cnt_d   = '0;
                    err_d   = bad_digit;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                x_sh_d  = x_sh_q >> DIGIT_W;
                y_sh_d  = y_sh_q >> DIGIT_W;
                res_d   = res_next;
                carry_d = dig_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(M - 1)) begin
                    diff_d  = res_next;
                    bout_d  = ~dig_cout;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_sh_q  <= '0;
            y_sh_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            carry_q <= 1'b0;
            bout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_sh_q  <= x_sh_d;
            y_sh_q  <= y_sh_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            carry_q <= carry_d;
            bout_q  <= bout_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Self-checking bench for bcd_subtractor_serial against a decimal reference model.
module tb_bcd_subtractor_serial;

    localparam int unsigned N = 12;
    localparam int unsigned M = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    // Last completed result, expected to hold until the next done.
    logic [N-1:0] held_diff;
    logic         held_bout;
    logic         held_err;

    bcd_subtractor_serial #(.N(N), .M(M)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd_val(input logic [N-1:0] v);
        int r = 0;
        for (int i = int'(M) - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [N-1:0] int_to_bcd(input int v);
        logic [N-1:0] r = '0;
        int t = v;
        for (int i = 0; i < int'(M); i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic has_bad(input logic [N-1:0] a, input logic [N-1:0] b);
        for (int i = 0; i < int'(M); i++)
            if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // Decimal reference: expected diff, borrow and error for one operation.
    task automatic model(input logic [N-1:0] xa, input logic [N-1:0] ya, input logic b,
                         output logic [N-1:0] ed, output logic eb, output logic ee);
        int modv = 1;
        int d;
        for (int i = 0; i < int'(M); i++) modv *= 10;
        ee = has_bad(xa, ya);
        d  = bcd_val(xa) - bcd_val(ya) - int'(b);
        eb = (d < 0);
        if (d < 0) d += modv;
        ed = int_to_bcd(d);
    endtask

    // Present operands with start high; called on a falling edge.
    task automatic issue(input logic [N-1:0] xa, input logic [N-1:0] ya, input logic b);
        x = xa; y = ya; bin = b; start = 1'b1;
    endtask

    // Deassert start after the accept edge, then follow the op to its done cycle.
    task automatic finish_op(input string tag, input logic [N-1:0] xa, input logic [N-1:0] ya,
                             input logic b);
        logic [N-1:0] ed;
        logic eb, ee;
        int busy_cnt = 0;
        int cyc = 0;
        model(xa, ya, b, ed, eb, ee);
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (busy) busy_cnt++;
            check({tag, " hold_diff"}, 32'(diff), 32'(held_diff));
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(M + 1));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(M));
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check({tag, " err"}, 32'(err), 32'(ee));
        if (!ee) begin
            check({tag, " diff"}, 32'(diff), 32'(ed));
            check({tag, " bout"}, 32'(bout), 32'(eb));
        end
        held_diff = diff; held_bout = bout; held_err = err;
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] xa, input logic [N-1:0] ya,
                          input logic b);
        issue(xa, ya, b);
        finish_op(tag, xa, ya, b);
    endtask

    function automatic logic [N-1:0] rand_bcd();
        logic [N-1:0] r;
        for (int i = 0; i < int'(M); i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    initial begin
        logic [N-1:0] rx, ry;
        logic         rb;
        int           cyc;

        rst = 1'b1; start = 1'b0; x = '0; y = '0; bin = 1'b0;
        held_diff = '0; held_bout = 1'b0; held_err = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset bout", 32'(bout), 32'd0);
        check("reset err",  32'(err),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op("t1", 12'h523, 12'h187, 1'b0);
        check("t1 exact", 32'(diff), 32'h336);
        @(negedge clk);
        run_op("t2a", 12'h187, 12'h523, 1'b0);
        check("t2a exact", 32'({bout, diff}), 32'h1664);
        run_op("t2b", 12'h000, 12'h000, 1'b1);      // back-to-back
        check("t2b exact", 32'({bout, diff}), 32'h1999);
        run_op("t3", 12'h999, 12'h999, 1'b0);       // back-to-back
        check("t3 exact", 32'({bout, diff}), 32'h0000);
        @(negedge clk);
        run_op("t4a", 12'h1A0, 12'h001, 1'b0);
        check("t4a exact_err", 32'(err), 32'd1);
        @(negedge clk);
        run_op("t4b", 12'h050, 12'h049, 1'b0);
        check("t4b exact", 32'({err, bout, diff}), 32'h001);

        // start pulsed during RUN with other operands must be ignored
        @(negedge clk);
        issue(12'h523, 12'h187, 1'b0);
        @(posedge clk);
        #1 x = 12'h111; y = 12'h888; bin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("t5 done", 32'(done), 32'd1);
        check("t5 diff", 32'(diff), 32'h336);
        check("t5 bout", 32'(bout), 32'd0);
        @(negedge clk);
        check("t5 no_rerun", 32'(busy), 32'd0);
        held_diff = diff;

        // Reset during the second RUN cycle aborts immediately
        run_op("t6pre", 12'h187, 12'h523, 1'b0);    // leaves non-zero outputs
        @(negedge clk);
        issue(12'h400, 12'h123, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6 busy", 32'(busy), 32'd0);
        check("t6 done", 32'(done), 32'd0);
        check("t6 diff", 32'(diff), 32'd0);
        check("t6 bout", 32'(bout), 32'd0);
        check("t6 err",  32'(err),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        held_diff = '0; held_bout = 1'b0; held_err = 1'b0;
        @(negedge clk);
        run_op("t6post", 12'h400, 12'h123, 1'b0);
        check("t6post exact", 32'(diff), 32'h277);

        // Random operations with random idle gaps (zero gap = back-to-back)
        for (int k = 0; k < 40; k++) begin
            rx = rand_bcd();
            ry = rand_bcd();
            rb = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) rx[4*$urandom_range(0, M-1) +: 4] = 4'($urandom_range(10, 15));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op("rand", rx, ry, rb);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
